sdf_feedback_fifo: RTL and testbench

//  Feedback delay line for a radix-2^2 SDF butterfly stage. Absorbs the stage's top-branch write

---
 rtl/fft_pkg.sv | 34 +++
 rtl/sdf_feedback_fifo_if.sv | 37 +++
 rtl/sdf_fifo_ram.sv | 36 +++
 rtl/sdf_feedback_fifo.sv | 112 +++++++++++
 tb/tb_sdf_feedback_fifo.sv | 144 ++++++++++++++
 5 files changed

// File: rtl/fft_pkg.sv
// rtl/fft_pkg.sv - shared FFT datapath package: complex sample layout and FIFO sizing
// Contents:
//   DWIDTH_DEF / DEPTH_LOG_DEF : default packed sample width and log2 FIFO depth
//   HWIDTH                     : width of one real or imaginary component
//   cplx_t                     : packed complex sample {re, im}, real in the upper half
//   cplx_pack / cplx_unpack    : convert between components and a packed sample
//   fifo_depth                 : DEPTH = 1 << DEPTH_LOG
package fft_pkg;

    localparam int DWIDTH_DEF    = 32;
    localparam int DEPTH_LOG_DEF = 3;
    localparam int HWIDTH        = DWIDTH_DEF / 2;

    typedef struct packed {
        logic [HWIDTH-1:0] re;
        logic [HWIDTH-1:0] im;
    } cplx_t;

    function automatic cplx_t cplx_pack(input logic [HWIDTH-1:0] re, input logic [HWIDTH-1:0] im);
        cplx_t c;
        c.re = re;
        c.im = im;
        return c;
    endfunction

    function automatic logic [2*HWIDTH-1:0] cplx_unpack(input cplx_t c);
        return {c.re, c.im};
    endfunction

    function automatic int fifo_depth(input int depth_log);
        return 1 << depth_log;
    endfunction

endpackage

// File: rtl/sdf_feedback_fifo_if.sv
// rtl/sdf_feedback_fifo_if.sv - write/read stream and status bundle of the SDF feedback FIFO
// Signals:
//   i_wr_data, i_wr_valid          : push stream from the butterfly top output (no backpressure)
//   o_rd_data, o_rd_valid          : FWFT head-of-queue stream
//   i_rd_ready                     : pop request from the butterfly
//   o_full, o_empty, o_count       : occupancy status
//   o_overflow, o_underflow        : sticky error flags
// Modports:
//   slave  : the FIFO side
//   master : the butterfly / environment side
interface sdf_feedback_fifo_if #(
    parameter int DWIDTH    = 32,
    parameter int DEPTH_LOG = 3
);

    logic [DWIDTH-1:0]    i_wr_data;
    logic                 i_wr_valid;
    logic [DWIDTH-1:0]    o_rd_data;
    logic                 o_rd_valid;
    logic                 i_rd_ready;
    logic                 o_full;
    logic                 o_empty;
    logic [DEPTH_LOG:0]   o_count;
    logic                 o_overflow;
    logic                 o_underflow;

    modport slave (
        input  i_wr_data, i_wr_valid, i_rd_ready,
        output o_rd_data, o_rd_valid, o_full, o_empty, o_count, o_overflow, o_underflow
    );

    modport master (
        output i_wr_data, i_wr_valid, i_rd_ready,
        input  o_rd_data, o_rd_valid, o_full, o_empty, o_count, o_overflow, o_underflow
    );

endinterface

// File: rtl/sdf_fifo_ram.sv
// rtl/sdf_fifo_ram.sv - DEPTH x DWIDTH register array, one synchronous write port, one asynchronous read port
// Ports:
//   clk      : rising-edge clock
//   wr_en    : write strobe, stores wr_data at wr_addr on the clock edge
//   wr_addr  : write address
//   wr_data  : write data
//   rd_addr  : read address
//   rd_data  : combinational read data
// Contents are intentionally not reset.
module sdf_fifo_ram
    import fft_pkg::*;
#(
    parameter int DWIDTH    = 32,
    parameter int DEPTH_LOG = 3
) (
    input  logic                 clk,
    input  logic                 wr_en,
    input  logic [DEPTH_LOG-1:0] wr_addr,
    input  logic [DWIDTH-1:0]    wr_data,
    input  logic [DEPTH_LOG-1:0] rd_addr,
    output logic [DWIDTH-1:0]    rd_data
);

    localparam int DEPTH = fifo_depth(DEPTH_LOG);

    logic [DWIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/sdf_feedback_fifo.sv
// rtl/sdf_feedback_fifo.sv - feedback delay line for a radix-2^2 SDF butterfly stage (FWFT FIFO)
// Ports:
//   clk    : rising-edge clock
//   reset  : synchronous, active-high reset
//   bus    : sdf_feedback_fifo_if.slave (write stream, FWFT read stream, status, sticky flags)
// Configuration:
//   SDF_FIFO_ERR_FLAGS_EN : when defined, o_overflow / o_underflow are sticky error flags;
//                           when undefined they are tied to 0 and have no flops.
module sdf_feedback_fifo
    import fft_pkg::*;
#(
    parameter int DWIDTH    = 32,
    parameter int DEPTH_LOG = 3
) (
    input  logic                 clk,
    input  logic                 reset,
    sdf_feedback_fifo_if.slave   bus
);

    localparam int DEPTH = fifo_depth(DEPTH_LOG);
    localparam int CNT_W = DEPTH_LOG + 1;

    logic [DEPTH_LOG-1:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]     count_q,  count_d;

    logic full;
    logic empty;
    logic push;
    logic pop;

    always_comb begin
        full  = (count_q == CNT_W'(DEPTH));
        empty = (count_q == '0);
        pop   = bus.i_rd_ready && !empty;
        // A pop in the same cycle frees the head slot, so a full FIFO still accepts the push.
        push  = bus.i_wr_valid && (!full || pop);
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        if (push && !pop) begin
            count_d = count_q + 1'b1;
        end else if (pop && !push) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

`ifdef SDF_FIFO_ERR_FLAGS_EN
    logic overflow_q,  overflow_d;
    logic underflow_q, underflow_d;

    always_comb begin
        overflow_d  = overflow_q  || (bus.i_wr_valid && !push);
        underflow_d = underflow_q || (bus.i_rd_ready && empty);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    assign bus.o_overflow  = overflow_q;
    assign bus.o_underflow = underflow_q;
`else
    assign bus.o_overflow  = 1'b0;
    assign bus.o_underflow = 1'b0;
`endif

    sdf_fifo_ram #(
        .DWIDTH    (DWIDTH),
        .DEPTH_LOG (DEPTH_LOG)
    ) u_ram (
        .clk     (clk),
        .wr_en   (push),
        .wr_addr (wr_ptr_q),
        .wr_data (bus.i_wr_data),
        .rd_addr (rd_ptr_q),
        .rd_data (bus.o_rd_data)
    );

    assign bus.o_rd_valid = !empty;
    assign bus.o_full     = full;
    assign bus.o_empty    = empty;
    assign bus.o_count    = count_q;

endmodule

// File: tb/tb_sdf_feedback_fifo.sv
// tb/tb_sdf_feedback_fifo.sv - self-checking bench for sdf_feedback_fifo against a queue model
module tb_sdf_feedback_fifo;

    localparam int DW    = 32;
    localparam int DLOG  = 3;
    localparam int DEPTH = 8;

`ifdef SDF_FIFO_ERR_FLAGS_EN
    localparam bit FLAGS_EN = 1'b1;
`else
    localparam bit FLAGS_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset;

    sdf_feedback_fifo_if #(.DWIDTH(DW), .DEPTH_LOG(DLOG)) bus ();

    sdf_feedback_fifo #(.DWIDTH(DW), .DEPTH_LOG(DLOG)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    logic [DW-1:0] model_q [$];
    bit            m_ovf;
    bit            m_unf;
    int            n_checks = 0;
    int            n_fails  = 0;

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Compare every observable output against the model; called away from the clock edge.
    task automatic check_state(input string tag);
        int sz;
        sz = model_q.size();
        chk({tag, ".valid"}, 32'(bus.o_rd_valid), 32'(sz > 0));
        chk({tag, ".empty"}, 32'(bus.o_empty),    32'(sz == 0));
        chk({tag, ".full"},  32'(bus.o_full),     32'(sz == DEPTH));
        chk({tag, ".count"}, 32'(bus.o_count),    32'(sz));
        if (sz > 0) begin
            chk({tag, ".data"}, bus.o_rd_data, model_q[0]);
        end
        chk({tag, ".ovf"}, 32'(bus.o_overflow),  32'(m_ovf && FLAGS_EN));
        chk({tag, ".unf"}, 32'(bus.o_underflow), 32'(m_unf && FLAGS_EN));
    endtask

    // One clock cycle of stimulus starting and ending at a falling edge.
    task automatic cycle(input string tag, input logic wv, input logic [DW-1:0] wd, input logic rr);
        bit do_pop;
        bit do_push;
        bus.i_wr_valid = wv;
        bus.i_wr_data  = wd;
        bus.i_rd_ready = rr;
        do_pop  = rr && (model_q.size() > 0);
        do_push = wv && ((model_q.size() < DEPTH) || do_pop);
        if (wv && !do_push) m_ovf = 1'b1;
        if (rr && model_q.size() == 0) m_unf = 1'b1;
        @(posedge clk);
        if (do_pop)  void'(model_q.pop_front());
        if (do_push) model_q.push_back(wd);
        @(negedge clk);
        check_state(tag);
    endtask

    task automatic do_reset(input int cycles);
        reset          = 1'b1;
        bus.i_wr_valid = 1'b0;
        bus.i_wr_data  = '0;
        bus.i_rd_ready = 1'b0;
        repeat (cycles) @(posedge clk);
        model_q.delete();
        m_ovf = 1'b0;
        m_unf = 1'b0;
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        m_ovf = 1'b0;
        m_unf = 1'b0;

        // Reset state
        do_reset(2);
        check_state("reset");

        // Fill then drain
        for (int i = 1; i <= 8; i++) cycle("fill", 1'b1, {16'(i), 16'(i)}, 1'b0);
        chk("fill.full_lit",  32'(bus.o_full),  32'd1);
        chk("fill.count_lit", 32'(bus.o_count), 32'd8);
        chk("fill.head_lit",  bus.o_rd_data,    32'h00010001);
        for (int i = 0; i < 8; i++) cycle("drain", 1'b0, '0, 1'b1);
        chk("drain.empty_lit", 32'(bus.o_empty), 32'd1);

        // Steady state across pointer wrap
        for (int i = 1; i <= 8; i++) cycle("refill", 1'b1, 32'(i), 1'b0);
        for (int i = 9; i <= 24; i++) begin
            chk("steady.lag", bus.o_rd_data, 32'(i - 8));
            cycle("steady", 1'b1, 32'(i), 1'b1);
        end
        chk("steady.count_lit", 32'(bus.o_count), 32'd8);

        // Overflow: dropped word, sticky flag, drain order intact
        cycle("ovf", 1'b1, 32'hDEADBEEF, 1'b0);
        chk("ovf.count_lit", 32'(bus.o_count), 32'd8);
        cycle("ovf.idle", 1'b0, '0, 1'b0);
        for (int i = 0; i < 8; i++) begin
            chk("ovf.drain", bus.o_rd_data, 32'(17 + i));
            cycle("ovf.drain", 1'b0, '0, 1'b1);
        end

        // Underflow and write-to-read latency
        cycle("unf", 1'b0, '0, 1'b1);
        cycle("lat", 1'b1, 32'h12345678, 1'b0);
        chk("lat.valid_lit", 32'(bus.o_rd_valid), 32'd1);
        chk("lat.data_lit",  bus.o_rd_data,       32'h12345678);
        cycle("lat.pop", 1'b0, '0, 1'b1);

        // Reset mid-operation with five words queued
        for (int i = 0; i < 5; i++) cycle("pre_rst", 1'b1, 32'hA000_0000 + 32'(i), 1'b0);
        chk("pre_rst.count_lit", 32'(bus.o_count), 32'd5);
        do_reset(1);
        check_state("mid_rst");
        cycle("post_rst", 1'b1, 32'hCAFE0001, 1'b0);
        chk("post_rst.head_lit", bus.o_rd_data, 32'hCAFE0001);

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            cycle("rand", 1'($urandom_range(0, 99) < 55), $urandom, 1'($urandom_range(0, 99) < 50));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
